bsg_mul_iterative_sequencer: RTL and testbench

- Request/response front-end wrapped around the iterative 64-bit Booth multiplier (valid/ready in, valid/yumi out).
- Accepts RISC-V M-extension multiply ops and issues operands with signedness to the multiplier.
- Consumes the 2*width_p product, selects or corrects the result word and holds it for the pipeline until yumi.
- One op in flight; MULHSU is synthesized from a signed x signed product plus a correction add.

---
 rtl/bsg_mul_iterative_sequencer_pkg.sv | 40 ++++
 rtl/bsg_mul_result_format.sv | 37 +++
 rtl/bsg_mul_iterative_sequencer.sv | 139 +++++++++++++
 tb/tb_bsg_mul_iterative_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mul_iterative_sequencer_pkg.sv
// Shared types and op-decode helpers for the iterative multiplier sequencer.
package bsg_mul_iterative_seq_pkg;

    typedef enum logic [2:0] {
        eMUL    = 3'd0,
        eMULH   = 3'd1,
        eMULHSU = 3'd2,
        eMULHU  = 3'd3,
        eMULW   = 3'd4
    } mul_op_e;

    typedef enum logic [2:0] {
        eIdle  = 3'd0,
        eIssue = 3'd1,
        eWait  = 3'd2,
        eFix   = 3'd3,
        eResp  = 3'd4
    } seq_state_e;

    // Unused encodings 5-7 fold onto MUL.
    function automatic mul_op_e op_decode(logic [2:0] raw);
        case (raw)
            3'd1:    return eMULH;
            3'd2:    return eMULHSU;
            3'd3:    return eMULHU;
            3'd4:    return eMULW;
            default: return eMUL;
        endcase
    endfunction

    // MULHSU runs signed x signed and is corrected afterwards.
    function automatic logic op_needs_signed(mul_op_e op);
        return (op != eMULHU);
    endfunction

    function automatic logic op_is_high(mul_op_e op);
        return (op == eMULH) || (op == eMULHSU) || (op == eMULHU);
    endfunction

endpackage

// File: rtl/bsg_mul_result_format.sv
// Combinational result-word selection and MULHSU high-word correction.
module bsg_mul_result_format
    import bsg_mul_iterative_seq_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic [2*width_p-1:0] prod,
    input  logic [2:0]           op,
    input  logic [width_p-1:0]   opA,
    input  logic [width_p-1:0]   opB,
    output logic [width_p-1:0]   word,
    output logic [width_p-1:0]   hi_fixed
);

    localparam int half_lp = width_p / 2;

    mul_op_e            op_e;
    logic [width_p-1:0] hi;
    logic [width_p-1:0] lo;

    assign op_e = mul_op_e'(op);
    assign hi   = prod[2*width_p-1:width_p];
    assign lo   = prod[width_p-1:0];

    // Treating rs2 as signed lost 2^width_p * rs1 when rs2's MSB is set.
    assign hi_fixed = hi + (opB[width_p-1] ? opA : '0);

    always_comb begin
        word = lo;
        if (op_is_high(op_e)) begin
            word = hi;
        end else if (op_e == eMULW) begin
            word = {{half_lp{lo[half_lp-1]}}, lo[half_lp-1:0]};
        end
    end

endmodule

// File: rtl/bsg_mul_iterative_sequencer.sv
// Request/response sequencer in front of the iterative Booth multiplier.
// Optional product reuse is enabled by defining BSG_MUL_ITER_SEQ_REUSE_EN.
module bsg_mul_iterative_sequencer
    import bsg_mul_iterative_seq_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int tag_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [2:0]             op_i,
    input  logic [width_p-1:0]     opA_i,
    input  logic [width_p-1:0]     opB_i,
    input  logic [tag_width_p-1:0] tag_i,
    output logic                   mul_v_o,
    input  logic                   mul_ready_i,
    output logic [width_p-1:0]     mul_opA_o,
    output logic [width_p-1:0]     mul_opB_o,
    output logic                   mul_signed_o,
    input  logic                   mul_v_i,
    input  logic [2*width_p-1:0]   mul_result_i,
    output logic                   mul_yumi_o,
    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

    seq_state_e             state, state_n;
    mul_op_e                op_r, op_in;
    logic [width_p-1:0]     opA_r, opB_r;
    logic [tag_width_p-1:0] tag_r;
    logic [2*width_p-1:0]   prod_r;
    logic [2*width_p-1:0]   hit_prod;
    logic [width_p-1:0]     word, hi_fixed;
    logic                   accept, hit;

    assign op_in  = op_decode(op_i);
    assign accept = v_i & ready_o;

    assign ready_o      = (state == eIdle);
    assign mul_v_o      = (state == eIssue);
    assign mul_yumi_o   = (state == eWait) & mul_v_i;
    assign v_o          = (state == eResp);
    assign mul_opA_o    = opA_r;
    assign mul_opB_o    = opB_r;
    assign mul_signed_o = op_needs_signed(op_r);
    assign result_o     = word;
    assign tag_o        = tag_r;

`ifdef BSG_MUL_ITER_SEQ_REUSE_EN
    logic [width_p-1:0]   last_opA, last_opB;
    logic                 last_signed;
    logic [2*width_p-1:0] last_prod;
    logic                 reuse_v;

    // Low-half ops are sign-independent, so any cached product serves them.
    assign hit = reuse_v && (opA_i == last_opA) && (opB_i == last_opB) &&
                 ((op_in == eMUL) || (op_in == eMULW) ||
                  (op_needs_signed(op_in) == last_signed));
    assign hit_prod = last_prod;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_opA    <= '0;
            last_opB    <= '0;
            last_signed <= 1'b0;
            last_prod   <= '0;
            reuse_v     <= 1'b0;
        end else if (mul_yumi_o) begin
            last_opA    <= opA_r;
            last_opB    <= opB_r;
            last_signed <= mul_signed_o;
            last_prod   <= mul_result_i;
            reuse_v     <= 1'b1;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_prod = '0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            eIdle: begin
                if (accept) begin
                    if (hit) state_n = (op_in == eMULHSU) ? eFix : eResp;
                    else     state_n = eIssue;
                end
            end
            eIssue:  if (mul_ready_i) state_n = eWait;
            eWait:   if (mul_v_i) state_n = (op_r == eMULHSU) ? eFix : eResp;
            eFix:    state_n = eResp;
            eResp:   if (yumi_i) state_n = eIdle;
            default: state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= eIdle;
            op_r   <= eMUL;
            opA_r  <= '0;
            opB_r  <= '0;
            tag_r  <= '0;
            prod_r <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_r  <= op_in;
                opA_r <= opA_i;
                opB_r <= opB_i;
                tag_r <= tag_i;
            end
            if (accept && hit) prod_r <= hit_prod;
            if (mul_yumi_o) prod_r <= mul_result_i;
            if (state == eFix) prod_r[2*width_p-1:width_p] <= hi_fixed;
        end
    end

    bsg_mul_result_format #(.width_p(width_p)) fmt (
        .prod     (prod_r),
        .op       (op_r),
        .opA      (opA_r),
        .opB      (opB_r),
        .word     (word),
        .hi_fixed (hi_fixed)
    );

`ifndef SYNTHESIS
    // A result outside eWait would be silently dropped.
    assert property (@(posedge clk_i) disable iff (!reset_n_i) mul_v_i |-> (state == eWait))
        else $error("mul_v_i asserted outside eWait");
`endif

endmodule

// File: tb/tb_bsg_mul_iterative_sequencer.sv
// Randomized bench for bsg_mul_iterative_sequencer with an arithmetic reference model.
module tb_bsg_mul_iterative_sequencer;

`ifdef BSG_MUL_ITER_SEQ_REUSE_EN
    localparam bit reuse_en = 1'b1;
`else
    localparam bit reuse_en = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         v_i;
    logic         ready_o;
    logic [2:0]   op_i;
    logic [63:0]  opA_i, opB_i;
    logic [4:0]   tag_i;
    logic         mul_v_o;
    logic         mul_ready_i;
    logic [63:0]  mul_opA_o, mul_opB_o;
    logic         mul_signed_o;
    logic         mul_v_i;
    logic [127:0] mul_result_i;
    logic         mul_yumi_o;
    logic         v_o;
    logic [63:0]  result_o;
    logic [4:0]   tag_o;
    logic         yumi_i;

    int n_vec = 0;
    int n_err = 0;

    logic        last_v = 1'b0;
    logic [63:0] last_a, last_b;
    logic        last_sgn;

    always #5 clk_i = ~clk_i;

    bsg_mul_iterative_sequencer #(.width_p(64), .tag_width_p(5)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .opA_i        (opA_i),
        .opB_i        (opB_i),
        .tag_i        (tag_i),
        .mul_v_o      (mul_v_o),
        .mul_ready_i  (mul_ready_i),
        .mul_opA_o    (mul_opA_o),
        .mul_opB_o    (mul_opB_o),
        .mul_signed_o (mul_signed_o),
        .mul_v_i      (mul_v_i),
        .mul_result_i (mul_result_i),
        .mul_yumi_o   (mul_yumi_o),
        .v_o          (v_o),
        .result_o     (result_o),
        .tag_o        (tag_o),
        .yumi_i       (yumi_i)
    );

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics computed directly in 128-bit modular arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, za, zb, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        za = {64'd0, a};
        zb = {64'd0, b};
        case (op)
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * zb; return p[127:64]; end
            3'd3: begin p = za * zb; return p[127:64]; end
            3'd4: begin p = za * zb; return {{32{p[31]}}, p[31:0]}; end
            default: begin p = za * zb; return p[63:0]; end
        endcase
    endfunction

    // What a multiplier would return for the operands and signedness it was given.
    function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b, input logic sgn);
        logic [127:0] xa, xb;
        xa = sgn ? {{64{a[63]}}, a} : {64'd0, a};
        xb = sgn ? {{64{b[63]}}, b} : {64'd0, b};
        return xa * xb;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input int iss_hold, input int resp_hold);
        logic [2:0]  nop;
        logic        exp_sgn, exp_hit;
        logic [63:0] exp_res;
        int          k, wd;
        nop     = (op > 3'd4) ? 3'd0 : op;
        exp_sgn = (nop != 3'd3);
        exp_hit = reuse_en && last_v && (a == last_a) && (b == last_b) &&
                  ((nop == 3'd0) || (nop == 3'd4) || (exp_sgn == last_sgn));
        exp_res = ref_result(nop, a, b);

        v_i = 1'b1; op_i = op; opA_i = a; opB_i = b; tag_i = tag;
        #1 check_value("ready_idle", ready_o, 1'b1);
        @(posedge clk_i); #1;
        v_i = 1'b0; opA_i = {$urandom, $urandom}; opB_i = {$urandom, $urandom}; tag_i = 5'($urandom);

        if (!exp_hit) begin
            for (int i = 0; i < iss_hold; i++) begin
                check_value("issue_hold_v", mul_v_o, 1'b1);
                check_value("issue_hold_opA", mul_opA_o, a);
                check_value("issue_hold_opB", mul_opB_o, b);
                @(posedge clk_i); #1;
            end
            check_value("issue_v", mul_v_o, 1'b1);
            check_value("issue_signed", mul_signed_o, exp_sgn);
            check_value("issue_opA", mul_opA_o, a);
            check_value("issue_opB", mul_opB_o, b);
            mul_ready_i = 1'b1;
            @(posedge clk_i); #1;
            mul_ready_i = 1'b0;
            check_value("issue_drop", mul_v_o, 1'b0);
            wd = $urandom_range(0, 3);
            for (int i = 0; i < wd; i++) begin
                check_value("wait_no_yumi", mul_yumi_o, 1'b0);
                @(posedge clk_i); #1;
            end
            mul_result_i = mul_model(mul_opA_o, mul_opB_o, mul_signed_o);
            mul_v_i = 1'b1;
            #1 check_value("mul_yumi", mul_yumi_o, 1'b1);
            @(posedge clk_i); #1;
            mul_v_i = 1'b0;
            mul_result_i = {4{$urandom}};
        end else begin
            check_value("hit_no_issue", mul_v_o, 1'b0);
        end

        k = 0;
        while (v_o !== 1'b1 && k < 8) begin
            check_value("no_issue_after_capture", mul_v_o, 1'b0);
            @(posedge clk_i); #1;
            k++;
        end
        check_value("latency", k, (nop == 3'd2) ? 1 : 0);

        for (int i = 0; i < resp_hold; i++) begin
            check_value("resp_hold_v", v_o, 1'b1);
            check_value("resp_hold_result", result_o, exp_res);
            check_value("resp_hold_tag", tag_o, tag);
            check_value("resp_hold_ready", ready_o, 1'b0);
            v_i = (i == 0);
            @(posedge clk_i); #1;
        end
        v_i = 1'b0;
        check_value("resp_v", v_o, 1'b1);
        check_value("result", result_o, exp_res);
        check_value("tag", tag_o, tag);
        yumi_i = 1'b1;
        @(posedge clk_i); #1;
        yumi_i = 1'b0;
        check_value("resp_done", v_o, 1'b0);
        check_value("back_idle", ready_o, 1'b1);
        check_value("idle_no_issue", mul_v_o, 1'b0);

        if (!exp_hit) begin
            last_v = 1'b1; last_a = a; last_b = b; last_sgn = exp_sgn;
        end
    endtask

    task automatic reset_mid_op();
        v_i = 1'b1; op_i = 3'd1; opA_i = 64'h1234_5678_9abc_def0; opB_i = 64'h0fed_cba9_8765_4321; tag_i = 5'd9;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        mul_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mul_ready_i = 1'b0;
        mul_result_i = mul_model(mul_opA_o, mul_opB_o, mul_signed_o);
        mul_v_i = 1'b1;
        #1 check_value("rst_pre_yumi", mul_yumi_o, 1'b1);
        #1 reset_n_i = 1'b0;
        #1;
        check_value("rst_async_v", v_o, 1'b0);
        check_value("rst_async_mul_v", mul_v_o, 1'b0);
        check_value("rst_async_yumi", mul_yumi_o, 1'b0);
        check_value("rst_async_ready", ready_o, 1'b1);
        mul_v_i = 1'b0;
        last_v = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            check_value("rst_no_resp", v_o, 1'b0);
            check_value("rst_idle", ready_o, 1'b1);
        end
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'($urandom_range(0, 15));
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] ra, rb;
        reset_n_i = 1'b0;
        v_i = 1'b0; op_i = 3'd0; opA_i = '0; opB_i = '0; tag_i = '0;
        mul_ready_i = 1'b0; mul_v_i = 1'b0; mul_result_i = '0; yumi_i = 1'b0;
        #1;
        check_value("reset_ready", ready_o, 1'b1);
        check_value("reset_v", v_o, 1'b0);
        check_value("reset_mul_v", mul_v_o, 1'b0);
        check_value("reset_yumi", mul_yumi_o, 1'b0);
        check_value("reset_result", result_o, 64'd0);
        check_value("reset_tag", tag_o, 5'd0);
        check_value("reset_opA", mul_opA_o, 64'd0);
        check_value("reset_opB", mul_opB_o, 64'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        do_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 4, 5);
        do_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 0, 1);
        do_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5'd30, 1, 0);
        do_op(3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd5, 0, 2);
        do_op(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 2, 0);
        do_op(3'd6, 64'd7, 64'd9, 5'd2, 0, 0);

        ra = 64'hDEAD_BEEF_0123_4567; rb = 64'hF00D_CAFE_8899_AABB;
        do_op(3'd1, ra, rb, 5'd10, 0, 1);
        do_op(3'd0, ra, rb, 5'd11, 0, 1);
        do_op(3'd2, ra, rb, 5'd12, 0, 1);
        do_op(3'd3, ra, rb, 5'd13, 1, 1);
        do_op(3'd4, ra, rb, 5'd14, 0, 0);

        reset_mid_op();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0 || !last_v) begin
                ra = pick_operand();
                rb = pick_operand();
            end
            do_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
